// File: rtl/counter_key_ctrl.sv
// Count-key sequencer: synchronise and debounce the key, qualify presses by switch popcount,
// drive a saturating counter. Optional autorepeat enabled by COUNTER_KEY_CTRL_AUTOREPEAT_EN.
module counter_key_ctrl #(
  parameter int SW_WIDTH        = 10,
  parameter int CNT_WIDTH       = 8,
  parameter int THRESHOLD       = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic                 clk100_i,
  input  logic                 rstn_i,
  input  logic                 key_i,
  input  logic [SW_WIDTH-1:0]  sw_i,
  input  logic                 clr_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 inc_o,
  output logic                 rej_o,
  output logic                 ovf_o,
  output logic [1:0]           state_o
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    DEB_PRESS = 2'b01,
    PRESSED   = 2'b10,
    DEB_REL   = 2'b11
  } state_t;

  function automatic int unsigned popcount(input logic [SW_WIDTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < SW_WIDTH; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  logic                key_p0, key_p1;
  logic [SW_WIDTH-1:0] sw_p0, sw_p1;
  state_t              state_q, state_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic                confirm;
  logic                qualified;

  // Stage p0/p1: two-flop synchronisers; key idles released (high)
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      key_p0 <= key_i;
      key_p1 <= key_p0;
      sw_p0  <= sw_i;
      sw_p1  <= sw_p0;
    end
  end

`ifdef COUNTER_KEY_CTRL_AUTOREPEAT_EN
  localparam int RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;

  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) rpt_q <= '0;
    else         rpt_q <= rpt_d;
  end
`endif

  // Debounce FSM state register
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      deb_q   <= '0;
    end else begin
      state_q <= state_d;
      deb_q   <= deb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    confirm = 1'b0;
`ifdef COUNTER_KEY_CTRL_AUTOREPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      IDLE: begin
        if (!key_p1) begin
          state_d = DEB_PRESS;
          deb_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (key_p1) begin
          state_d = IDLE;
        end else if (deb_q == DEB_LAST) begin
          state_d = PRESSED;
          confirm = 1'b1;
`ifdef COUNTER_KEY_CTRL_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      PRESSED: begin
        if (key_p1) begin
          state_d = DEB_REL;
          deb_d   = '0;
        end else begin
`ifdef COUNTER_KEY_CTRL_AUTOREPEAT_EN
          if (rpt_q == RPT_LAST) begin
            confirm = 1'b1;
            rpt_d   = '0;
          end else begin
            rpt_d = rpt_q + RPT_W'(1);
          end
`endif
        end
      end
      DEB_REL: begin
        if (!key_p1) begin
          state_d = PRESSED;
`ifdef COUNTER_KEY_CTRL_AUTOREPEAT_EN
          rpt_d   = '0;
`endif
        end else if (deb_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign qualified = (popcount(sw_p1) > THRESHOLD);
  assign state_o   = state_q;

  // Counter stage: clear is applied last so it overrides a same-edge increment
  always_ff @(posedge clk100_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_o <= '0;
      inc_o <= 1'b0;
      rej_o <= 1'b0;
      ovf_o <= 1'b0;
    end else begin
      inc_o <= 1'b0;
      rej_o <= 1'b0;
      if (confirm) begin
        if (qualified) begin
          if (cnt_o != '1) begin
            cnt_o <= cnt_o + CNT_WIDTH'(1);
            inc_o <= 1'b1;
          end else begin
            ovf_o <= 1'b1;
          end
        end else begin
          rej_o <= 1'b1;
        end
      end
      if (clr_i) begin
        cnt_o <= '0;
        ovf_o <= 1'b0;
        inc_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_counter_key_ctrl.sv
// Randomised bench for counter_key_ctrl against a run-length debounce model.
module tb_counter_key_ctrl;

  localparam int SW  = 10;
  localparam int CW  = 3;
  localparam int TH  = 3;
  localparam int DEB = 4;
  localparam int REP = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          key = 1'b1;
  logic [SW-1:0] sw = '0;
  logic          clr = 1'b0;
  logic [CW-1:0] cnt;
  logic          inc, rej, ovf;
  logic [1:0]    state;

  counter_key_ctrl #(
    .SW_WIDTH(SW), .CNT_WIDTH(CW), .THRESHOLD(TH),
    .DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .clk100_i(clk), .rstn_i(rstn), .key_i(key), .sw_i(sw), .clr_i(clr),
    .cnt_o(cnt), .inc_o(inc), .rej_o(rej), .ovf_o(ovf), .state_o(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model: synchroniser pipeline, debounced level, and length of the disagreeing run
  bit          m_k1, m_k2;
  logic [SW-1:0] m_s1, m_s2;
  bit          m_lvl;
  int          m_run, m_rep, m_cnt;
  bit          m_inc, m_rej, m_ovf;

  function automatic int pc(input logic [SW-1:0] v);
    int n = 0;
    for (int i = 0; i < SW; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic int exp_state();
    if (m_lvl) return (m_run > 0) ? 1 : 0;
    return (m_run > 0) ? 3 : 2;
  endfunction

  task automatic model_reset();
    m_k1 = 1'b1; m_k2 = 1'b1; m_s1 = '0; m_s2 = '0;
    m_lvl = 1'b1; m_run = 0; m_rep = 0; m_cnt = 0;
    m_inc = 1'b0; m_rej = 1'b0; m_ovf = 1'b0;
  endtask

  task automatic model_step();
    bit ks;
    logic [SW-1:0] ss;
    bit conf;
`ifdef COUNTER_KEY_CTRL_AUTOREPEAT_EN
    int run_prev;
    run_prev = m_run;
`endif
    ks = m_k2; ss = m_s2;
    m_k2 = m_k1; m_s2 = m_s1; m_k1 = key; m_s1 = sw;
    conf = 1'b0;
    if (ks != m_lvl) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_lvl = ks; m_run = 0; m_rep = 0;
        if (!m_lvl) conf = 1'b1;
      end
    end else begin
      m_run = 0;
`ifdef COUNTER_KEY_CTRL_AUTOREPEAT_EN
      if (!m_lvl) begin
        if (run_prev > 0) m_rep = 0;
        else begin
          m_rep++;
          if (m_rep == REP) begin m_rep = 0; conf = 1'b1; end
        end
      end
`endif
    end
    m_inc = 1'b0; m_rej = 1'b0;
    if (conf) begin
      if (pc(ss) > TH) begin
        if (m_cnt < CMAX) begin m_cnt++; m_inc = 1'b1; end
        else m_ovf = 1'b1;
      end else m_rej = 1'b1;
    end
    if (clr) begin m_cnt = 0; m_ovf = 1'b0; m_inc = 1'b0; end
  endtask

  task automatic check();
    tests++;
    if (int'(cnt) != m_cnt || inc !== m_inc || rej !== m_rej || ovf !== m_ovf ||
        int'(state) != exp_state()) begin
      fails++;
      $display("FAIL model cyc=%0d: got cnt=%0d inc=%b rej=%b ovf=%b st=%0d, want cnt=%0d inc=%b rej=%b ovf=%b st=%0d",
               cyc, cnt, inc, rej, ovf, state, m_cnt, m_inc, m_rej, m_ovf, exp_state());
    end
  endtask

  task automatic lit(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    if (rstn) model_step(); else model_reset();
    @(negedge clk);
    cyc++;
    check();
  endtask

  int first, ninc, nrej;

  task automatic run_key(input bit lv, input int n);
    for (int i = 0; i < n; i++) begin
      key = lv;
      tick();
      if (inc) ninc++;
      if (rej) nrej++;
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    // Reset held: random activity must not disturb outputs
    for (int i = 0; i < 10; i++) begin
      key = 1'($urandom); sw = SW'($urandom); clr = 1'($urandom);
      tick();
    end
    lit("rst_state", int'(state), 0);
    lit("rst_cnt", int'(cnt), 0);
    key = 1'b1; sw = '0; clr = 1'b0; rstn = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Single press: first inc after edge DEB+3
    sw = 10'h00F; first = 0; ninc = 0; nrej = 0;
    for (int i = 1; i <= 20; i++) begin
      key = 1'b0; tick();
      if (inc) begin ninc++; if (first == 0) first = i; end
    end
    run_key(1'b1, 12);
    lit("first_inc_edge", first, DEB + 3);
    lit("press_cnt", int'(cnt), 1);
    lit("idle_after_rel", int'(state), 0);
`ifndef COUNTER_KEY_CTRL_AUTOREPEAT_EN
    lit("press_inc_count", ninc, 1);
`endif

    // Press bounce and release bounce
    ninc = 0;
    run_key(1'b0, 3); run_key(1'b1, 1); run_key(1'b0, 12);
    run_key(1'b1, 2); run_key(1'b0, 4); run_key(1'b1, 12);
    lit("bounce_inc_count", ninc, 1);
    lit("bounce_cnt", int'(cnt), 2);

    // Popcount at threshold is rejected
    sw = 10'h007; ninc = 0; nrej = 0;
    run_key(1'b0, 10); run_key(1'b1, 12);
    lit("rej_count", nrej, 1);
    lit("rej_inc_count", ninc, 0);
    lit("rej_cnt", int'(cnt), 2);

    // Saturation at CMAX with sticky overflow
    sw = 10'h3FF; ninc = 0;
    for (int p = 0; p < 6; p++) begin run_key(1'b0, 10); run_key(1'b1, 10); end
    lit("sat_cnt", int'(cnt), CMAX);
    lit("sat_ovf", int'(ovf), 1);
    lit("sat_inc_count", ninc, CMAX - 2);
    clr = 1'b1; tick(); clr = 1'b0;
    lit("clr_cnt", int'(cnt), 0);
    lit("clr_ovf", int'(ovf), 0);

    // Clear on the confirm edge beats the increment
    for (int i = 1; i <= DEB + 3; i++) begin
      key = 1'b0; clr = (i == DEB + 3); tick();
    end
    clr = 1'b0;
    lit("clr_conf_cnt", int'(cnt), 0);
    lit("clr_conf_inc", int'(inc), 0);
    run_key(1'b1, 12);

    // Randomised segments of key levels, switch churn, clears and resets
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      bit lv;
      lv  = ~key;
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DEB + 2) : $urandom_range(DEB + 3, 24);
      if ($urandom_range(0, 150) == 0) begin
        rstn = 1'b0; model_reset();
        tick(); tick();
        rstn = 1'b1;
      end
      for (int i = 0; i < len; i++) begin
        key = lv;
        if ($urandom_range(0, 7) == 0)
          sw = ($urandom_range(0, 1) == 0) ? SW'($urandom) : SW'($urandom & $urandom & $urandom);
        clr = ($urandom_range(0, 40) == 0);
        tick();
      end
      clr = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
